reg_bank_ctrl: RTL and testbench
================================

# reg_bank_ctrl

Parametrised successor to the single-port control-register memory: a configurable register bank with byte-lane write strobes, a programmable read latency, out-of-range access error reporting and an optional write-lock register. It sits between a simple sel/wr/addr bus master (testbench driver or CPU bridge) and the block-level control registers of a design.

## Interface
- ADDR_WIDTH, 8: address bus width.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- DEPTH, 200: number of implemented registers; DEPTH ≤ 2**ADDR_WIDTH.
- RESET_VAL, 32'h0000_1234: reset value of every register, truncated to DATA_WIDTH.
- RD_LATENCY, 2: cycles from read accept to rvalid; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- sel  in  1  transaction request.
- wr  in  1  1 = write, 0 = read; sampled with sel.
- addr  in  ADDR_WIDTH  register index.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte-lane write enables.
- ready  out  1  bank can accept a transaction this cycle.
- rdata  out  DATA_WIDTH  read data; 0 whenever rvalid = 0.
- rvalid  out  1  one-cycle read-data-valid pulse.
- err  out  1  one-cycle error pulse.

## Operation
- Accept: transaction accepted on a rising edge where sel & ready = 1. sel while ready = 0 is ignored (no error, no effect).
- Write accept: each byte lane i with wstrb[i] = 1 is updated; other lanes are kept. ready stays 1; back-to-back writes every cycle are legal. wstrb = 0 is a legal no-op write.
- Read accept: addr is captured, ready drops to 0, and an internal latency counter/pipeline of RD_LATENCY stages runs. Register content is sampled at the accept edge, so a write in the same cycle is impossible (only one transaction per cycle).
- Out of range (addr ≥ DEPTH): write is dropped; read returns rdata = 0. err pulses in both cases (timing below).
- States: IDLE (ready = 1) and RD_WAIT (ready = 0, counter counting). IDLE→RD_WAIT on read accept. RD_WAIT→IDLE when the counter reaches RD_LATENCY; rvalid is asserted in that cycle.
- Reset: all registers ← RESET_VAL; ready = 1; rvalid = 0; rdata = 0; err = 0; the read pipeline is flushed. A reset asserted during RD_WAIT aborts the read, and no rvalid is ever produced for it.

## Timing
- Write accepted at edge T: data is visible to a read accepted at edge T+1. err for a rejected write is high in cycle T..T+1 (registered, one cycle).
- Read accepted at edge T: ready = 0 from T until edge T+RD_LATENCY.
  - At edge T+RD_LATENCY: rvalid = 1, rdata is valid, err = 1 if out of range, and ready = 1, all for exactly one cycle.
  - A new transaction may be accepted at edge T+RD_LATENCY+1. Read-to-read throughput is one read per RD_LATENCY+1 cycles.
- RD_LATENCY = 1 gives the legacy behaviour: data one cycle after accept, and ready low for one cycle.
- No combinational path from inputs to outputs.

## Configuration
- REG_BANK_CTRL_WRITE_LOCK_EN defined:
  - Register DEPTH-1 is the LOCK register; only bit 0 is stored, other bits read 0, and it resets to 0 regardless of RESET_VAL.
  - While LOCK[0] = 1, writes to addresses 0..DEPTH-2 are dropped and pulse err.
  - LOCK is always writable, and reads are never blocked.
- Macro undefined: register DEPTH-1 is an ordinary register and no write is ever rejected for lock.

## Test plan
- Reset check: assert rst for 2 cycles with DATA_WIDTH = 32 → ready = 1, rvalid = 0, err = 0; reading addr 0 and addr 199 returns 32'h0000_1234.
- Byte strobes: write addr 5 with wdata = 32'hAABBCCDD, wstrb = 4'b0101, then read addr 5 → rdata = 32'h00BB00DD with RESET_VAL = 0 (32'h00BB12DD with the default RESET_VAL).
- Latency sweep: RD_LATENCY = 1..4, read addr 3 → rvalid exactly RD_LATENCY cycles after accept, ready low for exactly RD_LATENCY cycles, and sel during ready = 0 has no effect.
- Range error: write then read addr 200 (DEPTH = 200) → err pulses on each, the write is dropped, and the read returns rdata = 0 with rvalid = 1.
- Reset mid-read: RD_LATENCY = 3, read accepted, rst asserted one cycle later → no rvalid, ready = 1 after reset, and register contents equal RESET_VAL.
- Lock (macro defined): write 1 to addr 199, write 32'h1 to addr 0 → err pulses and addr 0 still reads RESET_VAL; write 0 to addr 199, then the write to addr 0 succeeds.

Source files
------------

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: parametrised control-register bank on a sel/wr/addr bus.
// - Byte-lane write strobes; writes complete in the accept cycle, ready stays 1.
// - Reads sample the register at accept and return it RD_LATENCY cycles later
//   with a one-cycle rvalid pulse; ready is low while the read is in flight.
// - Accesses with addr >= DEPTH raise a one-cycle err pulse: write errors
//   appear right after the accept edge, read errors together with rvalid.
// - Optional feature macro REG_BANK_CTRL_WRITE_LOCK_EN: register DEPTH-1
//   becomes a 1-bit LOCK register (resets to 0); while LOCK[0] = 1, writes to
//   addresses 0..DEPTH-2 are dropped and raise err.
// Bus handshake: a transaction is accepted on a rising edge where
// sel & ready = 1; sel while ready = 0 is ignored without side effects.
// All outputs come from flops; there is no combinational input-to-output path.
module reg_bank_ctrl #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 200,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = DATA_WIDTH'(32'h0000_1234),
  parameter int                    RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    err
);

  localparam int                  NB      = DATA_WIDTH / 8;
  localparam int                  LAST    = DEPTH - 1;
  localparam logic [2:0]          LAT_C   = 3'(RD_LATENCY);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_oor_q, rd_oor_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic                    in_range;
  logic                    wr_locked;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign in_range = ({1'b0, addr} < DEPTH_C);

`ifdef REG_BANK_CTRL_WRITE_LOCK_EN
  // LOCK blocks every in-range register except itself.
  assign wr_locked = mem_q[LAST][0] && (addr != ADDR_WIDTH'(LAST));
`else
  assign wr_locked = 1'b0;
`endif

  assign ready  = (state_q == IDLE);
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

  // Read mux: selects the addressed register (zero when nothing matches).
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) rd_word = mem_q[i];
    end
  end

  // Next-state, register-update and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    rd_oor_d  = rd_oor_q;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    mem_d     = mem_q;

    case (state_q)
      IDLE: begin
        if (sel) begin
          if (wr) begin
            if (!in_range || wr_locked) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < DEPTH; i++) begin
                if (addr == ADDR_WIDTH'(i)) begin
                  for (int b = 0; b < NB; b++) begin
                    if (wstrb[b]) mem_d[i][8*b +: 8] = wdata[8*b +: 8];
                  end
                end
              end
            end
          end else begin
            // Content is captured now; the pipeline only delays its delivery.
            state_d   = RD_WAIT;
            cnt_d     = 3'd1;
            rd_data_d = in_range ? rd_word : '0;
            rd_oor_d  = !in_range;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == LAT_C) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = rd_data_q;
          err_d    = rd_oor_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef REG_BANK_CTRL_WRITE_LOCK_EN
    // Only bit 0 of LOCK is stored; the remaining bits always read 0.
    mem_d[LAST] = {{(DATA_WIDTH-1){1'b0}}, mem_d[LAST][0]};
`endif
  end

  // State, pipeline and register storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_oor_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_q     <= '{default: RESET_VAL};
`ifdef REG_BANK_CTRL_WRITE_LOCK_EN
      mem_q[LAST] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_oor_q  <= rd_oor_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: randomized bench for reg_bank_ctrl against a behavioural
// register-file model. Inputs are driven on the falling edge; outputs are
// sampled 1 time unit after the rising edge.
module tb_reg_bank_ctrl;

  localparam int          AW   = 8;
  localparam int          DW   = 32;
  localparam int          NB   = DW / 8;
  localparam int          DEPTH = 200;
  localparam logic [DW-1:0] RV = 32'h0000_1234;
  localparam int          LAT  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic          exp_err_q[$];

  reg_bank_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RESET_VAL  (RV),
    .RD_LATENCY (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .ready  (ready),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = RV;
`ifdef REG_BANK_CTRL_WRITE_LOCK_EN
    ref_mem[DEPTH-1] = '0;
`endif
  endfunction

  // Applies a write to the model; returns 1 when the write must be rejected.
  function automatic bit model_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    if (a >= DEPTH) return 1'b1;
`ifdef REG_BANK_CTRL_WRITE_LOCK_EN
    if (a == DEPTH-1) begin
      if (s[0]) ref_mem[a] = DW'(d[0]);
      return 1'b0;
    end
    if (ref_mem[DEPTH-1][0]) return 1'b1;
`endif
    for (int b = 0; b < NB; b++) begin
      if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] model_read(input int a);
    return (a < DEPTH) ? ref_mem[a] : '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    exp_err_q.delete();
    check_eq("rst_ready", ready, 1);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rdata", rdata, 0);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    bit exp_err;
    @(negedge clk);
    check_eq("wr_ready", ready, 1);
    sel = 1'b1; wr = 1'b1; addr = AW'(a); wdata = d; wstrb = s;
    exp_err = model_write(a, d, s);
    @(posedge clk); #1;
    sel = 1'b0;
    check_eq("wr_err", err, exp_err);
    check_eq("wr_rvalid", rvalid, 0);
  endtask

  // Reads a and checks latency, ready profile, data and err. With noise set,
  // sel is held high with a random write while ready is low (must be ignored).
  task automatic do_read(input int a, input bit noise, output logic [DW-1:0] got);
    int  lat;
    bit  seen;
    logic [DW-1:0] exp_d;
    logic          exp_e;
    @(negedge clk);
    check_eq("rd_ready", ready, 1);
    sel = 1'b1; wr = 1'b0; addr = AW'(a);
    wdata = $urandom; wstrb = NB'($urandom);
    exp_q.push_back(model_read(a));
    exp_err_q.push_back(a >= DEPTH);
    @(posedge clk); #1;
    if (noise) begin
      wr = 1'b1; addr = AW'($urandom_range(0, DEPTH-1));
      wdata = $urandom; wstrb = '1;
    end else begin
      sel = 1'b0;
    end
    check_eq("rd_busy_ready", ready, 0);
    check_eq("rd_busy_rvalid", rvalid, 0);
    lat = 0;
    seen = 1'b0;
    got = '0;
    while (!seen && lat < LAT + 4) begin
      @(posedge clk); #1;
      lat++;
      if (rvalid) seen = 1'b1;
      else check_eq("rd_wait_ready", ready, 0);
    end
    sel = 1'b0;
    if (!seen) begin
      check_eq("rd_timeout", 0, 1);
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
    end else begin
      exp_d = exp_q.pop_front();
      exp_e = exp_err_q.pop_front();
      got = rdata;
      check_eq("rd_latency", lat, LAT);
      check_eq("rd_data", rdata, exp_d);
      check_eq("rd_err", err, exp_e);
      check_eq("rd_done_ready", ready, 1);
      @(posedge clk); #1;
      check_eq("rd_pulse_rvalid", rvalid, 0);
      check_eq("rd_pulse_rdata", rdata, 0);
      check_eq("rd_pulse_err", err, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DW-1:0] v;
    int a;

    model_reset();
    do_reset();

    // Reset contents at both ends of the bank.
    do_read(0, 1'b0, v);
    check_eq("reset_val_0", v, RV);
    do_read(DEPTH-1, 1'b0, v);
    check_eq("reset_val_last", v, model_read(DEPTH-1));

    // Byte strobes over the reset value.
    do_write(5, 32'hAABBCCDD, 4'b0101);
    do_read(5, 1'b0, v);
    check_eq("strobe_rdata", v, 32'h00BB12DD);

    // No-op write and back-to-back writes.
    do_write(7, 32'hFFFF_FFFF, 4'b0000);
    do_write(8, 32'h1111_2222, 4'b1111);
    do_write(9, 32'h3333_4444, 4'b1100);
    do_read(7, 1'b0, v);
    do_read(8, 1'b0, v);
    do_read(9, 1'b0, v);

    // Reads with sel held during ready = 0 must leave address 3 untouched.
    do_write(3, 32'hCAFE_F00D, 4'b1111);
    do_read(3, 1'b1, v);
    do_read(3, 1'b1, v);
    check_eq("noise_ignored", v, 32'hCAFE_F00D);

    // Out of range write and read.
    do_write(DEPTH, 32'hDEAD_BEEF, 4'b1111);
    do_read(DEPTH, 1'b0, v);
    do_read(255, 1'b0, v);

`ifdef REG_BANK_CTRL_WRITE_LOCK_EN
    do_write(DEPTH-1, 32'h1, 4'b0001);
    do_write(0, 32'h1, 4'b1111);
    do_read(0, 1'b0, v);
    check_eq("lock_blocks", v, RV);
    do_read(DEPTH-1, 1'b0, v);
    check_eq("lock_readback", v, 32'h1);
    do_write(DEPTH-1, 32'h0, 4'b1111);
    do_write(0, 32'h1, 4'b1111);
    do_read(0, 1'b0, v);
    check_eq("unlock_write", v, 32'h1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      a = (($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, DEPTH-1));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, NB'($urandom));
      else do_read(a, 1'($urandom_range(0, 1)), v);
    end

    // Reset during an in-flight read aborts it.
    do_write(10, 32'h5555_AAAA, 4'b1111);
    @(negedge clk);
    sel = 1'b1; wr = 1'b0; addr = AW'(10);
    @(posedge clk); #1;
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      check_eq("midrd_rvalid", rvalid, 0);
      check_eq("midrd_ready", ready, 1);
    end
    do_read(10, 1'b0, v);
    check_eq("midrd_reset_val", v, RV);
    do_read(5, 1'b0, v);
    do_read(DEPTH-1, 1'b0, v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
